tile_map_controller: RTL

- Owns the 300-entry playfield tile map (20 columns x 15 rows of 32x32 tiles, 640x480 display).
- Provides a dedicated, never-stalling render read port for the color mapper.
- Provides one shared access port for the two tank logic blocks, with round-robin arbitration.
- Initializes the map to the default arena after reset; supports READ, WRITE and HIT (read, then destroy brick) operations.

---
 rtl/tile_map_controller.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/tile_map_controller.sv
// Playfield tile map: 20x15 tiles, never-stalling render read port,
// one round-robin-arbitrated access port shared by two tank blocks.
module tile_map_controller #(
    parameter int unsigned NUM_TILES = 300,
    parameter int unsigned COLS      = 20,
    parameter int unsigned ROWS      = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [2:0] RenderTile,
    input  logic [1:0] Req,
    input  logic [1:0] Op1,
    input  logic [1:0] Op2,
    input  logic [8:0] Addr1,
    input  logic [8:0] Addr2,
    input  logic [2:0] WData1,
    input  logic [2:0] WData2,
    output logic [1:0] Gnt,
    output logic [1:0] Done,
    output logic [2:0] RData,
    output logic       InitBusy
);

    localparam int unsigned AW = 9;   // tile index width
    localparam int unsigned TW = 3;   // tile code width
    localparam int unsigned CW = 5;   // column counter width
    localparam int unsigned RW = 4;   // row counter width
    localparam int unsigned PW = 10;  // pixel coordinate width

    localparam logic [AW-1:0] LAST_TILE = AW'(NUM_TILES - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
    localparam logic [PW-1:0] MAX_X     = PW'(COLS * 32);
    localparam logic [PW-1:0] MAX_Y     = PW'(ROWS * 32);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_HIT   = 2'b10;

    localparam logic [TW-1:0] TILE_EMPTY = TW'(0);
    localparam logic [TW-1:0] TILE_STEEL = TW'(1);
    localparam logic [TW-1:0] TILE_BRICK = TW'(2);
    localparam logic [TW-1:0] TILE_MAXOK = TW'(4);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [TW-1:0] wdata;
    } acc_req_t;

    state_t        state, state_n;
    logic [AW-1:0] init_cnt;
    logic [CW-1:0] init_col;
    logic [RW-1:0] init_row;
    logic          rr;          // 0 favours tank one, 1 favours tank two
    logic          sel_q, sel_n;
    acc_req_t      req_q, req_n;

    logic [1:0]    gnt_n;
    logic [1:0]    done_n;
    logic [TW-1:0] rdata_n;
    logic          busy_n;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [TW-1:0] wr_val;

    logic          addr_ok;
    logic [TW-1:0] old_val;
    logic          on_border;

    logic          render_ok;
    logic [AW-1:0] render_idx;
    logic          unused_draw_bits;

    logic [TW-1:0] map [NUM_TILES];

    // Current tile under the latched access; out-of-map reads look like steel
    always_comb begin
        addr_ok = (req_q.addr <= LAST_TILE);
        old_val = addr_ok ? map[req_q.addr] : TILE_STEEL;
    end

    // Border detection for the default arena
    always_comb begin
        on_border = (init_row == '0) || (init_row == LAST_ROW) ||
                    (init_col == '0) || (init_col == LAST_COL);
    end

    // Next state, registered-output next values and map write request
    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        req_n   = req_q;
        gnt_n   = 2'b00;
        done_n  = 2'b00;
        rdata_n = '0;
        busy_n  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = init_cnt;
        wr_val  = TILE_EMPTY;

        unique case (state)
            S_INIT: begin
                wr_en   = 1'b1;
                wr_addr = init_cnt;
                wr_val  = on_border ? TILE_STEEL : TILE_EMPTY;
                if (init_cnt == LAST_TILE) begin
                    state_n = S_IDLE;
                end else begin
                    busy_n = 1'b1;
                end
            end
            S_IDLE: begin
                if (Req != 2'b00) begin
                    if (Req == 2'b01) begin
                        sel_n = 1'b0;
                    end else if (Req == 2'b10) begin
                        sel_n = 1'b1;
                    end else begin
                        sel_n = rr;
                    end
                    req_n   = sel_n ? '{op: Op2, addr: Addr2, wdata: WData2}
                                    : '{op: Op1, addr: Addr1, wdata: WData1};
                    gnt_n   = sel_n ? 2'b10 : 2'b01;
                    state_n = S_ACCESS;
                end
            end
            S_ACCESS: begin
                done_n  = sel_q ? 2'b10 : 2'b01;
                rdata_n = old_val;
                wr_addr = req_q.addr;
                if (addr_ok) begin
                    if (req_q.op == OP_WRITE && req_q.wdata <= TILE_MAXOK) begin
                        wr_en  = 1'b1;
                        wr_val = req_q.wdata;
                    end else if (req_q.op == OP_HIT && old_val == TILE_BRICK) begin
                        wr_en  = 1'b1;
                        wr_val = TILE_EMPTY;
                    end
                end
                state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_INIT;
            end
        endcase
    end

    // State, init counters, arbitration pointer and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_INIT;
            init_cnt <= '0;
            init_col <= '0;
            init_row <= '0;
            rr       <= 1'b0;
            sel_q    <= 1'b0;
            req_q    <= '0;
            Gnt      <= 2'b00;
            Done     <= 2'b00;
            RData    <= '0;
            InitBusy <= 1'b1;
        end else begin
            state    <= state_n;
            sel_q    <= sel_n;
            req_q    <= req_n;
            Gnt      <= gnt_n;
            Done     <= done_n;
            RData    <= rdata_n;
            InitBusy <= busy_n;
            if (state == S_INIT) begin
                init_cnt <= init_cnt + AW'(1);
                if (init_col == LAST_COL) begin
                    init_col <= '0;
                    init_row <= init_row + RW'(1);
                end else begin
                    init_col <= init_col + CW'(1);
                end
            end
            if (state == S_ACCESS) begin
                rr <= ~sel_q;
            end
        end
    end

    // Tile storage; a reset cycle suppresses any pending write
    always_ff @(posedge Clk) begin
        if (!Reset && wr_en) begin
            map[wr_addr] <= wr_val;
        end
    end

    // Render address from the 32x32 tile grid
    always_comb begin
        render_ok        = (DrawX < MAX_X) && (DrawY < MAX_Y);
        render_idx       = AW'(DrawY[9:5]) * AW'(COLS) + AW'(DrawX[9:5]);
        unused_draw_bits = ^{DrawX[4:0], DrawY[4:0]};
    end

    // Render read port, one cycle latency, blank off-screen and during init
    always_ff @(posedge Clk) begin
        if (Reset) begin
            RenderTile <= '0;
        end else if (state == S_INIT || !render_ok) begin
            RenderTile <= '0;
        end else begin
            RenderTile <= map[render_idx];
        end
    end

endmodule
